// File: rtl/axil_reg_slave.sv
// ---------------------------------------------------------------------------
// axil_reg_slave
//   AXI4-Lite slave that turns bus transactions into a simple register-side
//   strobe interface. Writes and reads run on independent FSMs, each with a
//   single transaction outstanding.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   s_aw*/s_w*/s_b*                  AXI4-Lite write address/data/response
//   s_ar*/s_r*                       AXI4-Lite read address/data
//   address, write_en,               register-side write strobe; write_en
//   write_data, write_strb           pulses one cycle for in-range writes
//   rd_address, rd_data              register-side read; rd_data is sampled
//                                    one cycle after the AR handshake
// ---------------------------------------------------------------------------
module axil_reg_slave #(
    parameter int unsigned OFFSET        = 0,
    parameter int unsigned ADDRESS_STEP  = 4,
    parameter int unsigned NUM_ADDRESSES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    // write address / data
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    // write response
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    // read
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    // register side
    output logic [31:0] address,
    output logic        write_en,
    output logic [31:0] write_data,
    output logic [3:0]  write_strb,
    output logic [31:0] rd_address,
    input  logic [31:0] rd_data
);

    localparam logic [31:0] C_OFFSET = 32'(OFFSET);
    localparam logic [31:0] C_SPAN   = 32'(NUM_ADDRESSES * ADDRESS_STEP);
    localparam logic [31:0] C_STEP   = 32'(ADDRESS_STEP);
    localparam logic [1:0]  C_OKAY   = 2'b00;
    localparam logic [1:0]  C_SLVERR = 2'b10;

    // Range check done as a 33-bit subtraction: the borrow bit flags
    // addr < OFFSET, and comparing the offset against the span avoids any
    // overflow of OFFSET + span near the top of the address space.
    function automatic logic f_in_range(input logic [31:0] a);
        logic [32:0] diff;
        diff = {1'b0, a} - {1'b0, C_OFFSET};
        return !diff[32] && (diff[31:0] < C_SPAN) && ((diff[31:0] % C_STEP) == 32'd0);
    endfunction

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        W_IDLE, W_NEED_DATA, W_NEED_ADDR, W_EXEC, W_RESP
    } wstate_t;

    wstate_t     r_wstate, w_wnext;
    logic [31:0] r_address;
    logic [31:0] r_write_data;
    logic [3:0]  r_write_strb;
    logic [1:0]  r_bresp;
    logic        w_aw_hs, w_w_hs, w_wr_in_range;

    assign w_aw_hs       = s_awvalid && s_awready;
    assign w_w_hs        = s_wvalid && s_wready;
    assign w_wr_in_range = f_in_range(r_address);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wstate <= W_IDLE;
        else        r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext   = r_wstate;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        write_en  = 1'b0;
        s_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_awready = 1'b1;
                s_wready  = 1'b1;
                if (s_awvalid && s_wvalid) w_wnext = W_EXEC;
                else if (s_awvalid)        w_wnext = W_NEED_DATA;
                else if (s_wvalid)         w_wnext = W_NEED_ADDR;
            end
            W_NEED_DATA: begin
                s_wready = 1'b1;
                if (s_wvalid) w_wnext = W_EXEC;
            end
            W_NEED_ADDR: begin
                s_awready = 1'b1;
                if (s_awvalid) w_wnext = W_EXEC;
            end
            W_EXEC: begin
                write_en = w_wr_in_range;
                w_wnext  = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    // Captured address/data double as the register-side outputs; they hold
    // their last value outside W_EXEC since write_en qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_address    <= '0;
            r_write_data <= '0;
            r_write_strb <= '0;
            r_bresp      <= C_OKAY;
        end else begin
            if (w_aw_hs) r_address <= s_awaddr;
            if (w_w_hs) begin
                r_write_data <= s_wdata;
                r_write_strb <= s_wstrb;
            end
            if (r_wstate == W_EXEC) r_bresp <= w_wr_in_range ? C_OKAY : C_SLVERR;
        end
    end

    assign address    = r_address;
    assign write_data = r_write_data;
    assign write_strb = r_write_strb;
    assign s_bresp    = r_bresp;

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE, R_FETCH, R_RESP
    } rstate_t;

    rstate_t     r_rstate, w_rnext;
    logic [31:0] r_rd_address;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        w_ar_hs, w_rd_in_range;

    assign w_ar_hs       = s_arvalid && s_arready;
    assign w_rd_in_range = f_in_range(r_rd_address);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rstate <= R_IDLE;
        else        r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext   = r_rstate;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) w_rnext = R_FETCH;
            end
            R_FETCH: w_rnext = R_RESP;
            R_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read data is registered in R_FETCH so it stays stable through R_RESP
    // regardless of what rd_data does afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_address <= '0;
            r_rdata      <= '0;
            r_rresp      <= C_OKAY;
        end else begin
            if (w_ar_hs) r_rd_address <= s_araddr;
            if (r_rstate == R_FETCH) begin
                r_rdata <= w_rd_in_range ? rd_data : 32'h0;
                r_rresp <= w_rd_in_range ? C_OKAY : C_SLVERR;
            end
        end
    end

    assign rd_address = r_rd_address;
    assign s_rdata    = r_rdata;
    assign s_rresp    = r_rresp;

endmodule

// File: tb/tb_axil_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_slave
//   Directed stimulus with hand-computed literal expectations, plus a
//   transaction-level model that predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_axil_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] address;
    logic        write_en;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic [31:0] rd_address;
    logic [31:0] rd_data = '0;

    always #5 clk = ~clk;

    axil_reg_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .address(address), .write_en(write_en), .write_data(write_data),
        .write_strb(write_strb), .rd_address(rd_address), .rd_data(rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model (default parameters) --------
    function automatic bit m_in_range(input logic [31:0] a);
        longint x;
        x = longint'(a);
        return (x >= 0) && (x < 32 * 4) && ((x % 4) == 0);
    endfunction

    logic        m_have_aw, m_have_w, m_exec, m_bpend;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bcode;
    logic        m_fetch, m_rpend;
    logic [31:0] m_araddr, m_rval;
    logic [1:0]  m_rcode;
    logic        m_awready, m_wready, m_arready;

    // A channel accepts only while nothing is pending on that side.
    assign m_awready = !m_have_aw && !m_exec && !m_bpend;
    assign m_wready  = !m_have_w && !m_exec && !m_bpend;
    assign m_arready = !m_fetch && !m_rpend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have_aw <= 0; m_have_w <= 0; m_exec <= 0; m_bpend <= 0;
            m_awaddr <= 0; m_wdata <= 0; m_wstrb <= 0; m_bcode <= 0;
            m_fetch <= 0; m_rpend <= 0; m_araddr <= 0; m_rval <= 0; m_rcode <= 0;
        end else begin
            if (m_bpend && s_bready) m_bpend <= 0;
            if (m_exec) begin
                m_exec  <= 0;
                m_bpend <= 1;
                m_bcode <= m_in_range(m_awaddr) ? 2'b00 : 2'b10;
            end
            if (m_awready && s_awvalid) m_awaddr <= s_awaddr;
            if (m_wready && s_wvalid) begin
                m_wdata <= s_wdata;
                m_wstrb <= s_wstrb;
            end
            if ((m_have_aw || (m_awready && s_awvalid)) && (m_have_w || (m_wready && s_wvalid))) begin
                m_exec <= 1; m_have_aw <= 0; m_have_w <= 0;
            end else begin
                if (m_awready && s_awvalid) m_have_aw <= 1;
                if (m_wready && s_wvalid)   m_have_w  <= 1;
            end

            if (m_rpend && s_rready) m_rpend <= 0;
            if (m_fetch) begin
                m_fetch <= 0;
                m_rpend <= 1;
                m_rval  <= m_in_range(m_araddr) ? rd_data : 32'h0;
                m_rcode <= m_in_range(m_araddr) ? 2'b00 : 2'b10;
            end
            if (m_arready && s_arvalid) begin
                m_fetch  <= 1;
                m_araddr <= s_araddr;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_awready", 32'(s_awready), 32'(m_awready));
            chk("cyc_wready",  32'(s_wready),  32'(m_wready));
            chk("cyc_arready", 32'(s_arready), 32'(m_arready));
            chk("cyc_write_en", 32'(write_en), 32'(m_exec && m_in_range(m_awaddr)));
            chk("cyc_bvalid",  32'(s_bvalid),  32'(m_bpend));
            chk("cyc_rvalid",  32'(s_rvalid),  32'(m_rpend));
            if (m_exec) begin
                chk("cyc_address",    address,          m_awaddr);
                chk("cyc_write_data", write_data,       m_wdata);
                chk("cyc_write_strb", 32'(write_strb),  32'(m_wstrb));
            end
            if (m_bpend) chk("cyc_bresp", 32'(s_bresp), 32'(m_bcode));
            if (m_fetch) chk("cyc_rd_address", rd_address, m_araddr);
            if (m_rpend) begin
                chk("cyc_rdata", s_rdata, m_rval);
                chk("cyc_rresp", 32'(s_rresp), 32'(m_rcode));
            end
        end
    end

    // ---------------- directed stimulus ----------------------------------
    task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                            input logic exp_we, input logic [1:0] exp_resp);
        s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk); chk({nm, "_we"}, 32'(write_en), 32'(exp_we));
        @(negedge clk); chk({nm, "_bvalid"}, 32'(s_bvalid), 32'd1);
        chk({nm, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
        @(posedge clk); #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_rd_address", rd_address, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // simultaneous AW+W
        s_awaddr = 32'h08; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
        s_bready = 1; s_rready = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk);
        chk("t1_we", 32'(write_en), 32'd1);
        chk("t1_addr", address, 32'h08);
        chk("t1_data", write_data, 32'hDEADBEEF);
        chk("t1_bvalid_early", 32'(s_bvalid), 32'd0);
        @(negedge clk);
        chk("t1_bvalid", 32'(s_bvalid), 32'd1);
        chk("t1_bresp", 32'(s_bresp), 32'd0);
        chk("t1_awready_busy", 32'(s_awready), 32'd0);
        @(negedge clk);
        chk("t1_bvalid_done", 32'(s_bvalid), 32'd0);
        chk("t1_awready_idle", 32'(s_awready), 32'd1);
        @(posedge clk); #1;

        // AW at cycle 0, W at cycle 3
        s_awaddr = 32'h10; s_awvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0;
        @(negedge clk); chk("t2_awready_c1", 32'(s_awready), 32'd0);
        chk("t2_we_c1", 32'(write_en), 32'd0);
        @(negedge clk); chk("t2_awready_c2", 32'(s_awready), 32'd0);
        @(posedge clk); #1;
        s_wdata = 32'h1234; s_wstrb = 4'hF; s_wvalid = 1;
        @(negedge clk); chk("t2_awready_c3", 32'(s_awready), 32'd0);
        chk("t2_wready_c3", 32'(s_wready), 32'd1);
        @(posedge clk); #1;
        s_wvalid = 0;
        @(negedge clk); chk("t2_we_c4", 32'(write_en), 32'd1);
        chk("t2_addr", address, 32'h10);
        chk("t2_data", write_data, 32'h1234);
        @(negedge clk); chk("t2_bvalid_c5", 32'(s_bvalid), 32'd1);
        @(posedge clk); #1;

        // range boundaries
        do_write("oor_80", 32'h80, 32'h1, 1'b0, 2'b10);
        do_write("mis_06", 32'h06, 32'h2, 1'b0, 2'b10);
        do_write("last_7c", 32'h7C, 32'h3, 1'b1, 2'b00);
        do_write("first_00", 32'h00, 32'h4, 1'b1, 2'b00);
        do_write("top_fffc", 32'hFFFFFFFC, 32'h5, 1'b0, 2'b10);

        // W before AW, then held B with a new write waiting behind it
        s_bready = 0;
        s_wdata = 32'h55AA; s_wstrb = 4'h3; s_wvalid = 1;
        @(posedge clk); #1;
        s_wvalid = 0;
        @(negedge clk); chk("t3_wready", 32'(s_wready), 32'd0);
        chk("t3_awready", 32'(s_awready), 32'd1);
        @(posedge clk); #1;
        s_awaddr = 32'h20; s_awvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0;
        @(negedge clk); chk("t3_we", 32'(write_en), 32'd1);
        chk("t3_strb", 32'(write_strb), 32'h3);
        @(posedge clk); #1;
        s_awaddr = 32'h24; s_awvalid = 1; s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1;
        @(negedge clk); chk("t3_hold_bvalid", 32'(s_bvalid), 32'd1);
        chk("t3_hold_awready", 32'(s_awready), 32'd0);
        @(negedge clk); chk("t3_hold_bvalid2", 32'(s_bvalid), 32'd1);
        @(posedge clk); #1;
        s_bready = 1;
        @(posedge clk); #1;
        @(negedge clk); chk("t3_after_b_awready", 32'(s_awready), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk); chk("t3_we2", 32'(write_en), 32'd1);
        chk("t3_addr2", address, 32'h24);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // read with held rready
        s_rready = 0; rd_data = 32'hA5A5A5A5;
        s_araddr = 32'h04; s_arvalid = 1;
        @(posedge clk); #1;
        s_arvalid = 0;
        @(negedge clk); chk("t4_rd_address", rd_address, 32'h04);
        chk("t4_rvalid_early", 32'(s_rvalid), 32'd0);
        @(posedge clk); #1;
        rd_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_rvalid", 32'(s_rvalid), 32'd1);
            chk("t4_rdata", s_rdata, 32'hA5A5A5A5);
            chk("t4_arready", 32'(s_arready), 32'd0);
        end
        chk("t4_rresp", 32'(s_rresp), 32'd0);
        @(posedge clk); #1;
        s_rready = 1;
        @(posedge clk); #1;
        s_rready = 0;
        @(negedge clk); chk("t4_rvalid_done", 32'(s_rvalid), 32'd0);
        chk("t4_arready_idle", 32'(s_arready), 32'd1);

        // out-of-range read
        @(posedge clk); #1;
        s_rready = 1; rd_data = 32'hFFFFFFFF; s_araddr = 32'h81; s_arvalid = 1;
        @(posedge clk); #1;
        s_arvalid = 0;
        @(negedge clk);
        @(negedge clk); chk("t5_rvalid", 32'(s_rvalid), 32'd1);
        chk("t5_rdata", s_rdata, 32'h0);
        chk("t5_rresp", 32'(s_rresp), 32'd2);
        @(posedge clk); #1;

        // concurrent write and read
        s_bready = 1; s_rready = 1; rd_data = 32'h13579BDF;
        s_awaddr = 32'h0C; s_awvalid = 1; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1;
        s_araddr = 32'h0C; s_arvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        @(negedge clk); chk("t6_we", 32'(write_en), 32'd1);
        chk("t6_rd_address", rd_address, 32'h0C);
        @(negedge clk); chk("t6_bvalid", 32'(s_bvalid), 32'd1);
        chk("t6_rvalid", 32'(s_rvalid), 32'd1);
        chk("t6_rdata", s_rdata, 32'h13579BDF);
        @(posedge clk); #1;

        // reset during W_EXEC and R_RESP
        s_bready = 0; s_rready = 0; rd_data = 32'h0BADF00D;
        s_araddr = 32'h08; s_arvalid = 1;
        @(posedge clk); #1;
        s_arvalid = 0;
        s_awaddr = 32'h08; s_awvalid = 1; s_wdata = 32'h1; s_wstrb = 4'hF; s_wvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk); chk("t7_we_pre", 32'(write_en), 32'd1);
        chk("t7_rvalid_pre", 32'(s_rvalid), 32'd1);
        #1 rst_n = 0;
        #1;
        chk("t7_we_rst", 32'(write_en), 32'd0);
        chk("t7_rvalid_rst", 32'(s_rvalid), 32'd0);
        chk("t7_bvalid_rst", 32'(s_bvalid), 32'd0);
        chk("t7_rdata_rst", s_rdata, 32'd0);
        chk("t7_address_rst", address, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("t7_awready", 32'(s_awready), 32'd1);
        chk("t7_wready", 32'(s_wready), 32'd1);
        chk("t7_arready", 32'(s_arready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t7_no_bvalid", 32'(s_bvalid), 32'd0);
            chk("t7_no_rvalid", 32'(s_rvalid), 32'd0);
            chk("t7_no_we", 32'(write_en), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter OFFSET, default 0, byte address of register 0.
REQ-002 SHALL have parameter ADDRESS_STEP, default 4, byte spacing between registers.
REQ-003 SHALL have parameter NUM_ADDRESSES, default 32, number of registers in the decoded window.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have AXI4-Lite write ports: s_awaddr in 32, s_awvalid in 1, s_awready out 1, s_wdata in 32, s_wstrb in 4, s_wvalid in 1, s_wready out 1.
REQ-007 SHALL have AXI4-Lite response ports: s_bresp out 2, s_bvalid out 1, s_bready in 1.
REQ-008 SHALL have AXI4-Lite read ports: s_araddr in 32, s_arvalid in 1, s_arready out 1, s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1.
REQ-009 SHALL have register-side ports: address out 32, write_en out 1, write_data out 32, write_strb out 4, rd_address out 32, rd_data in 32; address and write_en drive the downstream address decoder.

Function
REQ-010 An address SHALL be in range iff OFFSET <= addr < OFFSET+NUM_ADDRESSES*ADDRESS_STEP and (addr-OFFSET) mod ADDRESS_STEP == 0; all compares in 32-bit unsigned.
REQ-011 Write FSM SHALL have states W_IDLE, W_NEED_DATA, W_NEED_ADDR, W_EXEC, W_RESP.
REQ-012 W_IDLE: s_awready=1, s_wready=1; AW and W both valid -> capture both, W_EXEC; AW only -> capture addr, W_NEED_DATA; W only -> capture data/strb, W_NEED_ADDR.
REQ-013 W_NEED_DATA: s_wready=1, s_awready=0; on s_wvalid capture -> W_EXEC. W_NEED_ADDR: s_awready=1, s_wready=0; on s_awvalid capture -> W_EXEC.
REQ-014 W_EXEC lasts exactly one cycle: address/write_data/write_strb = captured values; write_en=1 iff address in range, else 0; -> W_RESP.
REQ-015 W_RESP: s_bvalid=1, s_bresp=2'b00 (OKAY) if in range else 2'b10 (SLVERR); s_awready=s_wready=0; held stable until s_bready=1, then -> W_IDLE.
REQ-016 Write latency: final AW/W handshake at edge N -> write_en high in cycle N+1 -> s_bvalid high from cycle N+2.
REQ-017 write_en SHALL be 0 in every state except W_EXEC; address/write_data/write_strb SHALL hold last captured values otherwise.
REQ-018 Read FSM SHALL have states R_IDLE, R_FETCH, R_RESP, independent of the write FSM.
REQ-019 R_IDLE: s_arready=1; on s_arvalid capture s_araddr -> R_FETCH.
REQ-020 R_FETCH lasts one cycle: rd_address = captured addr; register s_rdata = rd_data if in range else 32'h0; -> R_RESP.
REQ-021 R_RESP: s_rvalid=1, s_rresp OKAY/SLVERR per REQ-010, s_rdata stable, s_arready=0; on s_rready -> R_IDLE.
REQ-022 Read latency: AR handshake at edge N -> s_rvalid high from cycle N+2; rd_data sampled at end of cycle N+1.
REQ-023 Simultaneous read and write SHALL proceed concurrently without stall; no ordering between channels is guaranteed.
REQ-024 Only one write and one read outstanding; back-to-back transactions SHALL accept new AW/W/AR no earlier than the cycle after B/R handshake.
REQ-025 Valid/response outputs SHALL never drop before the matching ready handshake.

Reset
REQ-026 rst_n low SHALL asynchronously force W_IDLE, R_IDLE, write_en=0, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, address=0, write_data=0, write_strb=0, rd_address=0.
REQ-027 Reset mid-transaction SHALL abandon it with no write_en pulse and no response after release; ready outputs SHALL be 1 from the first cycle after release.

Verification
REQ-028 AW=0x08 and W=0xDEADBEEF/strb 0xF same cycle, bready=1 -> write_en one cycle at N+1 with address 0x08, data 0xDEADBEEF; bvalid at N+2, bresp OKAY.
REQ-029 AW=0x10 at cycle 0, W=0x1234 at cycle 3 -> s_awready=0 cycles 1-3, write_en at cycle 4 with address 0x10, bvalid at cycle 5.
REQ-030 AW=0x80 (out of range, defaults) or 0x06 (misaligned) -> no write_en pulse, bresp 2'b10.
REQ-031 AR=0x04, rd_data=0xA5A5A5A5 in fetch cycle, rready held 0 for 3 cycles -> rd_address 0x04, rvalid stays high with rdata 0xA5A5A5A5 until rready, rresp OKAY.
REQ-032 Write and read issued same cycle -> both complete with latencies of REQ-016/REQ-022 unchanged.
REQ-033 rst_n pulled low during W_EXEC and R_RESP -> write_en, bvalid, rvalid go 0 immediately; after release awready/wready/arready=1 and no stray response.
